// File: rtl/nes_mem_arbiter.sv
// Single-port external memory arbiter for the NES core: the iNES loader owns the
// memory until loading is done, then CPU and PPU share it round-robin.
module nes_mem_arbiter #(
  parameter int unsigned WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic        load_write,
  input  logic        load_done,
  output logic        load_overflow,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_req,
  input  logic        ppu_we,
  input  logic [21:0] ppu_addr,
  input  logic [7:0]  ppu_wdata,
  output logic        ppu_ack,
  output logic [7:0]  ppu_rdata,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_oe,
  output logic        mem_we
);

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;
  typedef enum logic [1:0] {G_NONE, G_LOAD, G_CPU, G_PPU} grant_t;

  state_t          state;
  grant_t          grant;
  grant_t          next_grant;
  logic [CW-1:0]   wcnt;
  logic            last_ppu;
  logic            buf_valid;
  logic [AW-1:0]   buf_addr;
  logic [DW-1:0]   buf_data;
  logic            buf_consume;
  logic            run_mode;

  assign buf_consume = (state == S_ACK) && (grant == G_LOAD);
  assign run_mode    = load_done && !buf_valid;

  // Arbitration: loader only in LOAD mode, round-robin CPU/PPU in RUN mode
  always_comb begin
    next_grant = G_NONE;
    if (!run_mode) begin
      if (buf_valid) next_grant = G_LOAD;
    end else if (cpu_req && ppu_req) begin
      next_grant = last_ppu ? G_CPU : G_PPU;
    end else if (cpu_req) begin
      next_grant = G_CPU;
    end else if (ppu_req) begin
      next_grant = G_PPU;
    end
  end

  // One-entry loader buffer; a byte arriving while it is full and not draining is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid     <= 1'b0;
      buf_addr      <= '0;
      buf_data      <= '0;
      load_overflow <= 1'b0;
    end else if (load_write && (!buf_valid || buf_consume)) begin
      buf_valid <= 1'b1;
      buf_addr  <= load_addr;
      buf_data  <= load_data;
    end else begin
      if (load_write)  load_overflow <= 1'b1;
      if (buf_consume) buf_valid     <= 1'b0;
    end
  end

  // Access sequencer: IDLE -> ACCESS (WAIT+1 cycles) -> ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      grant     <= G_NONE;
      wcnt      <= '0;
      last_ppu  <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      ppu_ack   <= 1'b0;
      cpu_rdata <= '0;
      ppu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (next_grant != G_NONE) begin
            grant <= next_grant;
            wcnt  <= CW'(WAIT);
            state <= S_ACCESS;
            case (next_grant)
              G_LOAD: begin
                mem_addr  <= buf_addr;
                mem_wdata <= buf_data;
                mem_we    <= 1'b1;
                mem_oe    <= 1'b0;
              end
              G_CPU: begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_we    <= cpu_we;
                mem_oe    <= !cpu_we;
                last_ppu  <= 1'b0;
              end
              default: begin
                mem_addr  <= ppu_addr;
                mem_wdata <= ppu_wdata;
                mem_we    <= ppu_we;
                mem_oe    <= !ppu_we;
                last_ppu  <= 1'b1;
              end
            endcase
          end
        end
        S_ACCESS: begin
          if (wcnt == '0) begin
            if (mem_oe && (grant == G_CPU)) cpu_rdata <= mem_rdata;
            if (mem_oe && (grant == G_PPU)) ppu_rdata <= mem_rdata;
            mem_oe  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= (grant == G_CPU);
            ppu_ack <= (grant == G_PPU);
            state   <= S_ACK;
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Scoreboard bench for nes_mem_arbiter: expected writes and acks are queued as
// stimulus is driven and retired by a negedge monitor.
module tb_nes_mem_arbiter;

  localparam int unsigned WAIT = 2;

  logic        clk;
  logic        reset;
  logic [21:0] load_addr;
  logic [7:0]  load_data;
  logic        load_write;
  logic        load_done;
  logic        load_overflow;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ppu_req, ppu_we, ppu_ack;
  logic [21:0] ppu_addr;
  logic [7:0]  ppu_wdata, ppu_rdata;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_oe, mem_we;

  nes_mem_arbiter #(.WAIT(WAIT)) dut (
    .clk(clk), .reset(reset),
    .load_addr(load_addr), .load_data(load_data), .load_write(load_write),
    .load_done(load_done), .load_overflow(load_overflow),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small memory: PRG/CHR select bit plus the low six address bits
  logic [7:0] mem [0:127];
  logic [6:0] ridx;
  assign ridx      = {mem_addr[21], mem_addr[5:0]};
  assign mem_rdata = mem[ridx];
  always @(posedge clk) if (mem_we) mem[ridx] <= mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed { logic [21:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic ppu; logic [7:0] rdata; } ack_t;
  wr_t  wr_q[$];
  ack_t ack_q[$];

  // Monitor: write bursts, burst length, ack latency/port/data
  logic prev_act = 1'b0;
  int   burst_len = 0;
  int   rise_cyc = 0;
  int   ncyc = 0;
  always @(negedge clk) begin
    logic act;
    wr_t  w;
    ack_t a;
    ncyc++;
    act = mem_oe | mem_we;
    if (reset) begin
      prev_act  = 1'b0;
      burst_len = 0;
    end else begin
      if (act && !prev_act) begin
        rise_cyc  = ncyc;
        burst_len = 0;
        if (mem_we) begin
          check("write_expected", 32'(wr_q.size() > 0), 32'd1);
          if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(w.addr));
            check("write_data", 32'(mem_wdata), 32'(w.data));
          end
        end
      end
      if (act) burst_len++;
      if (!act && prev_act) check("burst_len", 32'(burst_len), 32'(WAIT + 1));
      if (cpu_ack || ppu_ack) begin
        check("ack_latency", 32'(ncyc - rise_cyc), 32'(WAIT + 1));
        check("ack_expected", 32'(ack_q.size() > 0), 32'd1);
        if (ack_q.size() > 0) begin
          a = ack_q.pop_front();
          check("ack_port", 32'(ppu_ack), 32'(a.ppu));
          check("ack_rdata", 32'(ppu_ack ? ppu_rdata : cpu_rdata), 32'(a.rdata));
        end
      end
      prev_act = act;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [21:0] a, input logic [7:0] d);
    load_addr  = a;
    load_data  = d;
    load_write = 1'b1;
    tick();
    load_write = 1'b0;
  endtask

  // Waits (bounded) for an ack on any port in mask {ppu,cpu}; n = cycles waited
  task automatic wait_ack(input logic [1:0] mask, output logic seen, output int n);
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      n++;
      if ((mask & {ppu_ack, cpu_ack}) != 2'b00) seen = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_oe"}, 32'(mem_oe), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_ppu_ack"}, 32'(ppu_ack), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_ppu_rdata"}, 32'(ppu_rdata), 32'd0);
    check({tag, "_overflow"}, 32'(load_overflow), 32'd0);
  endtask

  initial begin
    logic seen;
    int   n;
    int   blocked_acks;
    reset = 1'b1;
    load_addr = '0; load_data = '0; load_write = 1'b0; load_done = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_wdata = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Load phase: one byte every 8 cycles
    for (int i = 0; i < 16; i++) begin
      wr_q.push_back('{addr: 22'(i), data: 8'(8'hA0 + i)});
      load_byte(22'(i), 8'(8'hA0 + i));
      if (i != 15) repeat (7) tick();
    end
    // Land the first of three back-to-back strobes on the ACK of the last load byte
    repeat (4) tick();
    check("overflow_clean", 32'(load_overflow), 32'd0);
    wr_q.push_back('{addr: 22'h200000, data: 8'h5A});
    load_byte(22'h200000, 8'h5A);
    load_byte(22'h000021, 8'h66);
    load_byte(22'h000022, 8'h77);
    repeat (10) tick();
    check("overflow_set", 32'(load_overflow), 32'd1);

    // CPU blocked until load_done
    cpu_we = 1'b0; cpu_addr = 22'h000005; cpu_req = 1'b1;
    blocked_acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_ack) blocked_acks++;
    end
    check("blocked_no_ack", 32'(blocked_acks), 32'd0);
    ack_q.push_back('{ppu: 1'b0, rdata: 8'hA5});
    load_done = 1'b1;
    wait_ack(2'b01, seen, n);
    check("blocked_ack_seen", 32'(seen), 32'd1);
    check("blocked_ack_delay", 32'(n), 32'(WAIT + 2));
    cpu_req = 1'b0;
    repeat (3) tick();

    // Reset so last_grant points at PPU again
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Round-robin with both requests held
    for (int k = 0; k < 2; k++) begin
      ack_q.push_back('{ppu: 1'b0, rdata: 8'hA1});
      ack_q.push_back('{ppu: 1'b1, rdata: 8'h5A});
    end
    cpu_we = 1'b0; cpu_addr = 22'h000001; cpu_req = 1'b1;
    ppu_we = 1'b0; ppu_addr = 22'h200000; ppu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(2'b11, seen, n);
      check("rr_ack_seen", 32'(seen), 32'd1);
      if (k == 0) check("rr_first_delay", 32'(n), 32'(WAIT + 2));
      else        check("rr_spacing", 32'(n), 32'(WAIT + 3));
    end
    cpu_req = 1'b0;
    ppu_req = 1'b0;
    repeat (3) tick();

    // CPU write leaves rdata alone, then read it back
    wr_q.push_back('{addr: 22'h000030, data: 8'h77});
    ack_q.push_back('{ppu: 1'b0, rdata: 8'hA1});
    cpu_we = 1'b1; cpu_addr = 22'h000030; cpu_wdata = 8'h77; cpu_req = 1'b1;
    wait_ack(2'b01, seen, n);
    check("wr_ack_seen", 32'(seen), 32'd1);
    cpu_req = 1'b0;
    tick();
    ack_q.push_back('{ppu: 1'b0, rdata: 8'h77});
    cpu_we = 1'b0; cpu_req = 1'b1;
    wait_ack(2'b01, seen, n);
    check("rd_ack_seen", 32'(seen), 32'd1);
    cpu_req = 1'b0;
    repeat (3) tick();

    // Reset during an ACCESS of a CPU write
    wr_q.push_back('{addr: 22'h000010, data: 8'h3C});
    cpu_we = 1'b1; cpu_addr = 22'h000010; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    tick();
    check("midwr_mem_we", 32'(mem_we), 32'd1);
    tick();
    reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    check_reset_outputs("midreset");
    tick();
    reset = 1'b0;
    repeat (10) tick();

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
